// File: rtl/screen_fade_ctrl.sv
// screen_fade_ctrl: scene sequencer for the VGA output path.
// Picks one of three full-screen renderers (title, fight, game-over),
// steps a frame-synchronised scene FSM on start/KO events and ramps the
// brightness down and back up around every scene change. The final pixel
// is registered once on vga_clk.
//
// start_btn / p1_ko / p2_ko are levels. They are captured into pending
// flags on any cycle, but only in the scenes that accept them, and those
// flags are consumed on the next frame tick.
module screen_fade_ctrl #(
  parameter int FADE_DIV    = 2,    // frames per brightness step
  parameter int HOLD_FRAMES = 120   // frames game-over is shown before start counts
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        start_btn,
  input  logic        p1_ko,
  input  logic        p2_ko,
  input  logic [11:0] title_rgb,
  input  logic [11:0] fight_rgb,
  input  logic [11:0] gameover_rgb,
  output logic [1:0]  screen_sel,
  output logic        fading,
  output logic [1:0]  winner,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  localparam logic [1:0] SEL_TITLE    = 2'd0;
  localparam logic [1:0] SEL_FIGHT    = 2'd1;
  localparam logic [1:0] SEL_GAMEOVER = 2'd2;

  typedef enum logic [2:0] {
    ST_TITLE    = 3'd0,
    ST_FIGHT    = 3'd1,
    ST_GAMEOVER = 3'd2,
    ST_FADE_OUT = 3'd3,
    ST_FADE_IN  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          target_q, target_d;
  logic [1:0]          sel_q, sel_d;
  logic [4:0]          bright_q, bright_d;   // 0..16, 16 = full brightness
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                start_pend_q, ko_pend_q;
  logic [1:0]          winner_q;
  logic                start_clr, ko_clr, winner_clr;
  logic                prev_origin_q;
  logic                at_origin, tick;
  logic [11:0]         src;
  logic [8:0]          prod_r, prod_g, prod_b;
  logic [3:0]          red_q, green_q, blue_q;

  // Destination scene that a fade lands in once it completes.
  function automatic state_t sel_to_state(input logic [1:0] s);
    case (s)
      SEL_FIGHT:    return ST_FIGHT;
      SEL_GAMEOVER: return ST_GAMEOVER;
      default:      return ST_TITLE;
    endcase
  endfunction

  // A held (0,0) position yields only a single tick thanks to the
  // registered previous-cycle compare.
  assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign tick      = at_origin && !prev_origin_q;

  // Remember whether the previous cycle was at the frame origin.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) prev_origin_q <= 1'b0;
    else          prev_origin_q <= at_origin;
  end

  // Scene FSM next-state logic; everything here moves only on frame ticks.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    sel_d      = sel_q;
    bright_d   = bright_q;
    div_d      = div_q;
    hold_d     = hold_q;
    start_clr  = 1'b0;
    ko_clr     = 1'b0;
    winner_clr = 1'b0;
    if (tick) begin
      case (state_q)
        ST_TITLE: begin
          if (start_pend_q) begin
            state_d    = ST_FADE_OUT;
            target_d   = SEL_FIGHT;
            div_d      = '0;
            start_clr  = 1'b1;
            winner_clr = 1'b1;
          end
        end
        ST_FIGHT: begin
          if (ko_pend_q) begin
            state_d  = ST_FADE_OUT;
            target_d = SEL_GAMEOVER;
            div_d    = '0;
            ko_clr   = 1'b1;
          end
        end
        ST_GAMEOVER: begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
          if (start_pend_q) begin
            state_d   = ST_FADE_OUT;
            target_d  = SEL_TITLE;
            div_d     = '0;
            start_clr = 1'b1;
          end
        end
        ST_FADE_OUT: begin
          if (div_q == DIV_LAST) begin
            div_d    = '0;
            bright_d = bright_q - 5'd1;
            // Swap screens at black so the new scene fades in cleanly.
            if (bright_q == 5'd1) begin
              sel_d   = target_q;
              state_d = ST_FADE_IN;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_FADE_IN: begin
          if (div_q == DIV_LAST) begin
            div_d    = '0;
            bright_d = bright_q + 5'd1;
            if (bright_q == 5'd15) begin
              state_d = sel_to_state(target_q);
              if (target_q == SEL_GAMEOVER) hold_d = '0;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: state_d = ST_TITLE;
      endcase
    end
  end

  // Scene FSM registers; reset aborts any fade in progress.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q  <= ST_TITLE;
      target_q <= SEL_TITLE;
      sel_q    <= SEL_TITLE;
      bright_q <= 5'd16;
      div_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      bright_q <= bright_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
    end
  end

  // Pending start/KO latches; consumption on a tick wins over a new set.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      start_pend_q <= 1'b0;
      ko_pend_q    <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      if (start_clr)
        start_pend_q <= 1'b0;
      else if (start_btn && ((state_q == ST_TITLE) ||
                             ((state_q == ST_GAMEOVER) && (hold_q == HOLD_MAX))))
        start_pend_q <= 1'b1;

      if (ko_clr)
        ko_pend_q <= 1'b0;
      else if ((state_q == ST_FIGHT) && !ko_pend_q && (p1_ko || p2_ko))
        ko_pend_q <= 1'b1;

      // First KO in a fight decides the result: {p1_ko, p2_ko}.
      if (winner_clr)
        winner_q <= 2'b00;
      else if ((state_q == ST_FIGHT) && !ko_pend_q && (p1_ko || p2_ko))
        winner_q <= {p1_ko, p2_ko};
    end
  end

  // Source renderer selection follows the registered screen select.
  always_comb begin
    src = 12'h000;
    case (sel_q)
      SEL_TITLE:    src = title_rgb;
      SEL_FIGHT:    src = fight_rgb;
      SEL_GAMEOVER: src = gameover_rgb;
      default:      src = 12'h000;
    endcase
  end

  // Brightness scaling: (channel * bright) >> 4, exact at bright = 16.
  assign prod_r = 9'(src[11:8]) * 9'(bright_q);
  assign prod_g = 9'(src[7:4])  * 9'(bright_q);
  assign prod_b = 9'(src[3:0])  * 9'(bright_q);

  // Final pixel register; blanking forces black.
  always_ff @(posedge vga_clk) begin
    if (!reset_n || !blank) begin
      red_q   <= 4'h0;
      green_q <= 4'h0;
      blue_q  <= 4'h0;
    end else begin
      red_q   <= prod_r[7:4];
      green_q <= prod_g[7:4];
      blue_q  <= prod_b[7:4];
    end
  end

  assign screen_sel = sel_q;
  assign fading     = (state_q == ST_FADE_OUT) || (state_q == ST_FADE_IN);
  assign winner     = winner_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;

endmodule

// File: tb/tb_screen_fade_ctrl.sv
// tb_screen_fade_ctrl: directed bench for screen_fade_ctrl. A frame-level
// model (scene + ticks-into-fade counter) predicts outputs every cycle,
// and literal expectations at key points pin that model down.
module tb_screen_fade_ctrl;

  localparam int FD = 2;
  localparam int HF = 120;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, start_btn, p1_ko, p2_ko;
  logic [11:0] title_rgb, fight_rgb, gameover_rgb;
  logic [1:0]  screen_sel, winner;
  logic        fading;
  logic [3:0]  red, green, blue;

  always #5 clk = ~clk;

  screen_fade_ctrl #(.FADE_DIV(FD), .HOLD_FRAMES(HF)) dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .start_btn(start_btn), .p1_ko(p1_ko), .p2_ko(p2_ko),
    .title_rgb(title_rgb), .fight_rgb(fight_rgb), .gameover_rgb(gameover_rgb),
    .screen_sel(screen_sel), .fading(fading), .winner(winner),
    .red(red), .green(green), .blue(blue)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Scenes: 0 title, 1 fight, 2 gameover, 3 fading (k = ticks since fade began).
  int m_mode, m_k, m_target, m_screen, m_hold, m_winner;
  bit m_sp, m_kp, m_prev;
  logic [16:0] exp_q[$];   // {screen_sel, fading, winner, rgb}

  function automatic int m_bright();
    if (m_mode != 3) return 16;
    if (m_k < 16 * FD) return 16 - m_k / FD;
    return (m_k - 16 * FD) / FD;
  endfunction

  function automatic logic [3:0] scale(input logic [3:0] c, input int b);
    int p;
    p = int'(c) * b / 16;
    return p[3:0];
  endfunction

  always @(posedge clk) begin
    logic [11:0] src;
    logic [11:0] px;
    int b;
    bit tk, set_sp, set_kp, sp_old, kp_old, sp_use, kp_use, fad;
    if (!reset_n) begin
      m_mode = 0; m_k = 0; m_target = 0; m_screen = 0; m_hold = 0;
      m_winner = 0; m_sp = 0; m_kp = 0;
      px = 12'h000;
      m_prev = 0;
    end else begin
      b = m_bright();
      case (m_screen)
        0:       src = title_rgb;
        1:       src = fight_rgb;
        default: src = gameover_rgb;
      endcase
      px = blank ? {scale(src[11:8], b), scale(src[7:4], b), scale(src[3:0], b)} : 12'h000;
      tk = (DrawX == 10'd0) && (DrawY == 10'd0) && !m_prev;
      sp_old = m_sp; kp_old = m_kp; sp_use = 0; kp_use = 0;
      set_sp = start_btn && (m_mode == 0 || (m_mode == 2 && m_hold == HF));
      set_kp = (p1_ko || p2_ko) && m_mode == 1 && !kp_old;
      if (set_kp) m_winner = int'({p1_ko, p2_ko});
      if (tk) begin
        case (m_mode)
          0: if (sp_old) begin m_mode = 3; m_k = 0; m_target = 1; sp_use = 1; m_winner = 0; end
          1: if (kp_old) begin m_mode = 3; m_k = 0; m_target = 2; kp_use = 1; end
          2: begin
            if (m_hold < HF) m_hold++;
            if (sp_old) begin m_mode = 3; m_k = 0; m_target = 0; sp_use = 1; end
          end
          default: begin
            m_k++;
            if (m_k == 16 * FD) m_screen = m_target;
            if (m_k == 32 * FD) begin
              m_mode = m_target;
              m_k = 0;
              if (m_target == 2) m_hold = 0;
            end
          end
        endcase
      end
      m_sp = sp_use ? 1'b0 : (sp_old | set_sp);
      m_kp = kp_use ? 1'b0 : (kp_old | set_kp);
      m_prev = (DrawX == 10'd0) && (DrawY == 10'd0);
    end
    fad = (m_mode == 3);
    exp_q.push_back({2'(m_screen), fad, 2'(m_winner), px});
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty actual=0 required=1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_screen_sel", 12'(screen_sel), 12'(e[16:15]));
      check("sb_fading", 12'(fading), 12'(e[14]));
      check("sb_winner", 12'(winner), 12'(e[13:12]));
      check("sb_rgb", {red, green, blue}, e[11:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frame(input int len);
    @(negedge clk); DrawX = 10'd0; DrawY = 10'd0;
    for (int i = 1; i < len; i++) begin
      @(negedge clk); DrawX = 10'(i); DrawY = 10'd9;
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(4);
  endtask

  task automatic pulse_start();
    @(negedge clk); start_btn = 1'b1;
    @(negedge clk); start_btn = 1'b0;
  endtask

  task automatic pulse_ko(input logic a, input logic b);
    @(negedge clk); p1_ko = a; p2_ko = b;
    @(negedge clk); p1_ko = 1'b0; p2_ko = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0; DrawX = 10'd1; DrawY = 10'd1; blank = 1'b1;
    start_btn = 1'b0; p1_ko = 1'b0; p2_ko = 1'b0;
    title_rgb = 12'hF84; fight_rgb = 12'hFFF; gameover_rgb = 12'h3C5;

    repeat (3) @(negedge clk);
    check("rst_sel", 12'(screen_sel), 12'd0);
    check("rst_fading", 12'(fading), 12'd0);
    check("rst_winner", 12'(winner), 12'd0);
    check("rst_rgb", {red, green, blue}, 12'h000);
    reset_n = 1'b1;
    @(negedge clk);
    check("title_full", {red, green, blue}, 12'hF84);

    // Title -> fight, full 64-tick fade.
    title_rgb = 12'hFFF;
    pulse_start();
    frame(4);
    check("fade_start", 12'(fading), 12'd1);
    check("fade_start_sel", 12'(screen_sel), 12'd0);
    frames(16);
    check("bright8", {red, green, blue}, 12'h777);
    frames(16);
    check("black_sel", 12'(screen_sel), 12'd1);
    check("black_rgb", {red, green, blue}, 12'h000);
    frames(32);
    check("fight_fading", 12'(fading), 12'd0);
    check("fight_rgb", {red, green, blue}, 12'hFFF);
    check("fight_winner", 12'(winner), 12'd0);

    // Double KO -> draw; later KO ignored.
    pulse_ko(1'b1, 1'b1);
    check("draw", 12'(winner), 12'd3);
    frame(4);
    check("ko_fade", 12'(fading), 12'd1);
    pulse_ko(1'b0, 1'b1);
    check("late_ko", 12'(winner), 12'd3);
    frames(64);
    check("over_sel", 12'(screen_sel), 12'd2);
    check("over_fading", 12'(fading), 12'd0);
    check("over_rgb", {red, green, blue}, 12'h3C5);

    // Game-over hold: early start ignored, accepted only at HOLD_FRAMES.
    frames(50);
    pulse_start();
    frame(4);
    check("hold50", 12'(fading), 12'd0);
    frames(68);
    pulse_start();
    frame(4);
    check("hold119", 12'(fading), 12'd0);
    pulse_start();
    frame(4);
    check("hold120", 12'(fading), 12'd1);
    frames(64);
    check("back_title", 12'(screen_sel), 12'd0);
    check("winner_kept", 12'(winner), 12'd3);

    // Start held through fade-in is not latched in FIGHT.
    pulse_start();
    frame(4);
    check("winner_clear", 12'(winner), 12'd0);
    frames(32);
    start_btn = 1'b1;
    frames(32);
    frames(3);
    check("held_start_sel", 12'(screen_sel), 12'd1);
    check("held_start_fading", 12'(fading), 12'd0);
    start_btn = 1'b0;

    // P2 KO alone; blanking forces black while FSM advances.
    pulse_ko(1'b0, 1'b1);
    check("p2_ko", 12'(winner), 12'd1);
    blank = 1'b0;
    frame(4);
    check("blank_fading", 12'(fading), 12'd1);
    check("blank_rgb", {red, green, blue}, 12'h000);
    blank = 1'b1;
    frame(4);
    // Origin held five cycles: one tick only (k=2 -> bright 15).
    repeat (5) begin @(negedge clk); DrawX = 10'd0; DrawY = 10'd0; end
    @(negedge clk); DrawX = 10'd7; DrawY = 10'd3;
    @(negedge clk); DrawX = 10'd8;
    check("held_origin", {red, green, blue}, 12'hEEE);
    frames(16);
    check("bright7", {red, green, blue}, 12'h666);

    // Reset mid-fade aborts it.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_sel", 12'(screen_sel), 12'd0);
    check("midrst_fading", 12'(fading), 12'd0);
    check("midrst_winner", 12'(winner), 12'd0);
    check("midrst_rgb", {red, green, blue}, 12'h000);
    title_rgb = 12'hF84;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_rgb", {red, green, blue}, 12'hF84);
    frames(3);
    check("post_rst_idle", 12'(fading), 12'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
